// File: rtl/sr04_controller.sv
// HC-SR04 ultrasonic ranging controller: trigger pulse, echo timing in microseconds,
// conversion to centimetres, with out-of-range and no-echo handling.
module sr04_controller #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned ECHO_WAIT_US = 30000,
  parameter int unsigned ECHO_MAX_US  = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] distance
);

  localparam int unsigned DIV     = CLK_HZ / 1_000_000;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MAX_A   = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
  localparam int unsigned CNT_MAX = (MAX_A > ECHO_MAX_US) ? MAX_A : ECHO_MAX_US;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SUB_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       echo_sync;
  logic             start_btn_d;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [SUB_W-1:0] us_cnt;
  logic [8:0]       cm_cnt;

  logic echo_s;
  logic start_edge;
  logic tick;

  assign echo_s     = echo_sync[1];
  assign start_edge = start_btn & ~start_btn_d;
  assign tick       = (div == DIV_W'(DIV - 1));

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would leak new values into later reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      trig        <= 1'b0;
      distance    <= '0;
      echo_sync   <= '0;
      start_btn_d <= 1'b0;
      div         <= '0;
      cnt         <= '0;
      us_cnt      <= '0;
      cm_cnt      <= '0;
    end else begin
      echo_sync   <= {echo_sync[0], echo};
      start_btn_d <= start_btn;
      div         <= tick ? '0 : div + DIV_W'(1);

      // Every state change restarts the divider so each interval starts on a whole us.
      case (state)
        IDLE: begin
          trig <= 1'b0;
          if (start_edge) begin
            state <= TRIG;
            trig  <= 1'b1;
            div   <= '0;
            cnt   <= '0;
          end
        end

        TRIG: begin
          if (tick) begin
            if (cnt == CNT_W'(TRIG_US - 1)) begin
              state <= WAIT_ECHO;
              trig  <= 1'b0;
              div   <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        WAIT_ECHO: begin
          if (echo_s) begin
            state  <= MEASURE;
            div    <= '0;
            cnt    <= '0;
            us_cnt <= '0;
            cm_cnt <= '0;
          end else if (tick) begin
            if (cnt == CNT_W'(ECHO_WAIT_US - 1)) begin
              state <= IDLE;
              div   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        MEASURE: begin
          if (tick && cnt == CNT_W'(ECHO_MAX_US - 1)) begin
            distance <= 9'd511;
            state    <= IDLE;
            div      <= '0;
          end else begin
            // A tick landing on the falling-edge cycle still counts: the divider
            // restarted one cycle after echo_s rose, so the last us completes here.
            if (tick) begin
              cnt <= cnt + CNT_W'(1);
              if (us_cnt == SUB_W'(US_PER_CM - 1)) begin
                us_cnt <= '0;
                cm_cnt <= cm_cnt + 9'd1;
              end else begin
                us_cnt <= us_cnt + SUB_W'(1);
              end
            end
            if (!echo_s) begin
              state <= DONE;
              div   <= '0;
            end
          end
        end

        DONE: begin
          distance <= cm_cnt;
          state    <= IDLE;
          div      <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_controller.sv
// Directed bench for sr04_controller, run with a 2 MHz clock scale and shortened
// timeouts so every scenario fits in a short run.
module tb_sr04_controller;

  localparam int unsigned CLK_HZ       = 2_000_000;
  localparam int unsigned DIV          = 2;
  localparam int unsigned TRIG_US      = 10;
  localparam int unsigned US_PER_CM    = 58;
  localparam int unsigned ECHO_WAIT_US = 3000;
  localparam int unsigned ECHO_MAX_US  = 6000;
  localparam int          TRIG_CLKS    = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       echo;
  logic       trig;
  logic [8:0] distance;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sr04_controller #(
    .CLK_HZ      (CLK_HZ),
    .TRIG_US     (TRIG_US),
    .US_PER_CM   (US_PER_CM),
    .ECHO_WAIT_US(ECHO_WAIT_US),
    .ECHO_MAX_US (ECHO_MAX_US)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .echo     (echo),
    .trig     (trig),
    .distance (distance)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Raise start_btn, check trig rises one clock later and stays high TRIG_CLKS clocks.
  task automatic fire(input string tag, input bit hold);
    int lat;
    int width;
    @(negedge clk);
    start_btn = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!trig && lat < 10);
    check({tag, "_trig_lat"}, lat, 1);
    width = 0;
    while (trig && width < 5000) begin
      @(negedge clk);
      width++;
    end
    check({tag, "_trig_width"}, width, TRIG_CLKS);
    if (!hold) start_btn = 1'b0;
  endtask

  task automatic measure(input string tag, input int us, input int exp_cm);
    fire(tag, 1'b0);
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (us * DIV) @(negedge clk);
    echo = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_dist"}, int'(distance), exp_cm);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int highs;
    rst       = 1'b0;
    start_btn = 1'b0;
    echo      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_dist", int'(distance), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_trig", int'(trig), 0);

    // Held button: single trigger, then no-echo timeout and no retrigger while held.
    fire("basic", 1'b1);
    highs = 0;
    repeat (ECHO_WAIT_US * DIV + 200) begin
      @(negedge clk);
      if (trig) highs++;
    end
    check("hold_no_retrig", highs, 0);
    check("timeout0_dist", int'(distance), 0);
    start_btn = 1'b0;
    repeat (3) @(negedge clk);

    measure("short10", 10, 0);
    measure("r580", 580, 10);
    measure("r5800", 5800, 100);

    // No echo: distance keeps 100 and the next edge is accepted.
    fire("noecho", 1'b0);
    repeat (ECHO_WAIT_US * DIV + 100) @(negedge clk);
    check("noecho_dist", int'(distance), 100);
    measure("r57", 57, 0);

    // Overlong echo reports the out-of-range code.
    fire("over", 1'b0);
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (ECHO_MAX_US * DIV + 50) @(negedge clk);
    check("over_dist", int'(distance), 511);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    check("over_hold", int'(distance), 511);
    check("over_trig", int'(trig), 0);

    // Abort during MEASURE.
    fire("abort_m", 1'b0);
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_m_trig", int'(trig), 0);
    check("abort_m_dist", int'(distance), 0);
    rst  = 1'b1;
    echo = 1'b0;
    repeat (5) @(negedge clk);

    // Abort during TRIG.
    start_btn = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_t_mid", int'(trig), 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_t_trig", int'(trig), 0);
    rst       = 1'b1;
    start_btn = 1'b0;
    repeat (5) @(negedge clk);

    measure("recover", 580, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr04_controller.md
Name: sr04_controller

Overview:
Controller for an HC-SR04 ultrasonic ranging sensor. On a start request it emits a 10 us trigger pulse, then times the sensor's echo pulse in microseconds. It converts the echo width to centimetres (width_us / 58) and holds the result on a 9-bit register. It sits between a debounced start button or periodic request and the display/FND logic.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; sets the 1 us tick divider (CLK_HZ/1_000_000 cycles per tick).
TRIG_US, 10, trigger pulse width in us.
US_PER_CM, 58, echo microseconds per centimetre.
ECHO_WAIT_US, 30000, max wait for echo rising after trig ends.
ECHO_MAX_US, 25000, max echo high time before the measurement is declared out of range.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous active-low reset (rst=0 resets on next clk edge).
start_btn  in  1  measurement request, level input; its rising edge starts a measurement.
echo  in  1  asynchronous echo from sensor.
trig  out  1  trigger pulse to sensor.
distance  out  9  last measured distance in cm, unsigned.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, trig=0, distance=0, all counters and tick divider=0, synchronizer and edge registers=0.
- 1 us tick: free-running divider counts 0..CLK_HZ/1e6-1 and pulses tick for one cycle on wrap. The divider restarts at 0 on every state entry so timing is exact.
- echo passes through a 2-FF synchronizer; only the synchronized echo_s is used.
- start_btn is registered once. start_edge = start_btn & ~start_btn_d.
- States:
  - IDLE: trig=0. On start_edge, go to TRIG. start_btn held high does not retrigger.
  - TRIG: trig=1 for exactly TRIG_US ticks (1000 clk at defaults). Then trig=0 and go to WAIT_ECHO. trig rises on the clock after the start_edge cycle.
  - WAIT_ECHO: on echo_s=1, go to MEASURE and clear the us and cm counters. After ECHO_WAIT_US ticks with no echo, go to IDLE; distance is unchanged.
  - MEASURE: each tick increments the us sub-counter 0..US_PER_CM-1; on wrap, the cm counter increments. On echo_s falling (echo_s=0), go to DONE. If total echo time reaches ECHO_MAX_US ticks, set distance=9'd511 and go to IDLE.
  - DONE: one cycle. distance <= cm counter (floor(us/58)), then go to IDLE.
- distance holds its value between measurements and changes only in DONE or on out-of-range.
- start_edge outside IDLE is ignored; there is no queueing.
- cm counter max at ECHO_MAX_US is 431 and fits in 9 bits; 511 is reserved as the out-of-range code.
- Reset mid-operation aborts immediately: trig=0, distance=0, state=IDLE.
- Echo already high on entry to WAIT_ECHO starts MEASURE immediately.

Test Plan:
- Reset: rst=0 for 2 clk with echo=0 -> trig=0, distance=0. Release with start_btn=0 -> trig stays 0.
- Basic trigger: rising edge on start_btn, held 5 us -> trig high exactly 1000 clk starting 1 clk after the edge, then low. Holding start_btn does not retrigger.
- Short echo: after trig, echo high 10 us -> distance=0 after falling edge plus sync plus DONE latency (<=4 clk).
- Ranging: echo high 580 us -> distance=10. Next run with echo 5800 us -> distance=100. Next run with 57 us -> 0.
- No echo: start with echo held 0 for more than 30 ms -> returns to IDLE, distance keeps its previous value, and a new start_btn edge is accepted.
- Overlong echo and abort: echo held high more than 25 ms -> distance=511. Separately, rst=0 during MEASURE -> trig=0, distance=0 next edge.
